// File: rtl/vga_pkg.sv
// vga_pkg: 1024x768@60 raster timing constants (65 MHz pixel clock), counter
// widths, the registered timing bundle and a window-decode helper.
//
// Contents:
//   HCNT_W, VCNT_W   counter widths
//   HOR_* / VER_*    raster geometry: total length, sync start/length, blank start
//   vga_tim_t        {hcount, vcount, hsync, vsync, hblnk, vblnk}
//   in_window()      start <= value < start+len
package vga_pkg;

    localparam int HCNT_W = 11;
    localparam int VCNT_W = 11;

    localparam logic [HCNT_W-1:0] HOR_TOTAL_TIME  = 11'd1344;
    localparam logic [HCNT_W-1:0] HOR_BLANK_START = 11'd1024;
    localparam logic [HCNT_W-1:0] HOR_SYNC_START  = 11'd1048;
    localparam logic [HCNT_W-1:0] HOR_SYNC_TIME   = 11'd136;

    localparam logic [VCNT_W-1:0] VER_TOTAL_TIME  = 11'd806;
    localparam logic [VCNT_W-1:0] VER_BLANK_START = 11'd768;
    localparam logic [VCNT_W-1:0] VER_SYNC_START  = 11'd771;
    localparam logic [VCNT_W-1:0] VER_SYNC_TIME   = 11'd6;

    typedef struct packed {
        logic [HCNT_W-1:0] hcount;
        logic [VCNT_W-1:0] vcount;
        logic              hsync;
        logic              vsync;
        logic              hblnk;
        logic              vblnk;
    } vga_tim_t;

    // The end bound is computed one bit wider so start+len cannot wrap.
    // Draw stages reuse this for rectangle hit tests.
    function automatic logic in_window(
        input logic [HCNT_W-1:0] value,
        input logic [HCNT_W-1:0] start,
        input logic [HCNT_W-1:0] len
    );
        logic [HCNT_W:0] end_x;
        end_x = {1'b0, start} + {1'b0, len};
        return ({1'b0, value} >= {1'b0, start}) && ({1'b0, value} < end_x);
    endfunction

endpackage

// File: rtl/vga_timing_if.sv
// vga_timing_if: output bundle of the raster timing generator.
//
// Signals:
//   hcount, vcount       pixel / line position
//   hsync, vsync         active-high sync strobes
//   hblnk, vblnk         blanking strobes
//   line_start           one-cycle pulse at every horizontal wrap
//   frame_start          one-cycle pulse at every full-raster wrap
//   frame_cnt            completed frames since reset, modulo 2^FRAME_CNT_W
//   tim                  packed copy of position + strobes for downstream stages
// Modports: master (generator drives), slave (draw stages consume).
interface vga_timing_if #(
    parameter int unsigned FRAME_CNT_W = 16
);
    import vga_pkg::*;

    logic [HCNT_W-1:0]      hcount;
    logic [VCNT_W-1:0]      vcount;
    logic                   hsync;
    logic                   vsync;
    logic                   hblnk;
    logic                   vblnk;
    logic                   line_start;
    logic                   frame_start;
    logic [FRAME_CNT_W-1:0] frame_cnt;
    vga_tim_t               tim;

    modport master (
        output hcount, vcount, hsync, vsync, hblnk, vblnk,
               line_start, frame_start, frame_cnt, tim
    );

    modport slave (
        input  hcount, vcount, hsync, vsync, hblnk, vblnk,
               line_start, frame_start, frame_cnt, tim
    );

endinterface

// File: rtl/vga_timing.sv
// vga_timing: free-running raster timing generator, 1024x768@60 by default.
//
// Ports:
//   clk   in   pixel clock, rising edge
//   rst   in   synchronous active-high reset
//   en    in   pixel-advance enable
//   vga   out  vga_timing_if.master bundle (counters, strobes, pulses, frame_cnt)
//
// Geometry parameters default to vga_pkg; they are exposed so a reduced raster
// can be built for fast simulation without touching the package.
module vga_timing
    import vga_pkg::*;
#(
    parameter int unsigned       FRAME_CNT_W   = 16,
    parameter logic [HCNT_W-1:0] H_TOTAL       = HOR_TOTAL_TIME,
    parameter logic [HCNT_W-1:0] H_BLANK_START = HOR_BLANK_START,
    parameter logic [HCNT_W-1:0] H_SYNC_START  = HOR_SYNC_START,
    parameter logic [HCNT_W-1:0] H_SYNC_TIME   = HOR_SYNC_TIME,
    parameter logic [VCNT_W-1:0] V_TOTAL       = VER_TOTAL_TIME,
    parameter logic [VCNT_W-1:0] V_BLANK_START = VER_BLANK_START,
    parameter logic [VCNT_W-1:0] V_SYNC_START  = VER_SYNC_START,
    parameter logic [VCNT_W-1:0] V_SYNC_TIME   = VER_SYNC_TIME
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    vga_timing_if.master vga
);

    localparam logic [HCNT_W-1:0] H_LAST = H_TOTAL - HCNT_W'(1);
    localparam logic [VCNT_W-1:0] V_LAST = V_TOTAL - VCNT_W'(1);

    logic [HCNT_W-1:0]      hcount_q, h_nxt;
    logic [VCNT_W-1:0]      vcount_q, v_nxt;
    logic                   hsync_q, vsync_q, hblnk_q, vblnk_q;
    logic                   line_start_q, frame_start_q;
    logic [FRAME_CNT_W-1:0] frame_cnt_q;
    logic                   line_wrap, frame_wrap;

    always_comb begin
        h_nxt      = hcount_q;
        v_nxt      = vcount_q;
        line_wrap  = 1'b0;
        frame_wrap = 1'b0;
        if (en) begin
            if (hcount_q == H_LAST) begin
                h_nxt     = '0;
                line_wrap = 1'b1;
                if (vcount_q == V_LAST) begin
                    v_nxt      = '0;
                    frame_wrap = 1'b1;
                end else begin
                    v_nxt = vcount_q + VCNT_W'(1);
                end
            end else begin
                h_nxt = hcount_q + HCNT_W'(1);
            end
        end
    end

    // Strobes decode the next-state counters so the registered strobes line up
    // with the registered counters on the same cycle. While stalled the decode
    // of the held counters reproduces the held strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            hcount_q      <= '0;
            vcount_q      <= '0;
            hsync_q       <= 1'b0;
            vsync_q       <= 1'b0;
            hblnk_q       <= 1'b0;
            vblnk_q       <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            frame_cnt_q   <= '0;
        end else begin
            hcount_q      <= h_nxt;
            vcount_q      <= v_nxt;
            hsync_q       <= in_window(h_nxt, H_SYNC_START, H_SYNC_TIME);
            vsync_q       <= in_window(v_nxt, V_SYNC_START, V_SYNC_TIME);
            hblnk_q       <= (h_nxt >= H_BLANK_START);
            vblnk_q       <= (v_nxt >= V_BLANK_START);
            line_start_q  <= line_wrap;
            frame_start_q <= frame_wrap;
            if (frame_wrap) begin
                frame_cnt_q <= frame_cnt_q + {{(FRAME_CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign vga.hcount      = hcount_q;
    assign vga.vcount      = vcount_q;
    assign vga.hsync       = hsync_q;
    assign vga.vsync       = vsync_q;
    assign vga.hblnk       = hblnk_q;
    assign vga.vblnk       = vblnk_q;
    assign vga.line_start  = line_start_q;
    assign vga.frame_start = frame_start_q;
    assign vga.frame_cnt   = frame_cnt_q;
    assign vga.tim         = '{hcount: hcount_q, vcount: vcount_q,
                               hsync: hsync_q, vsync: vsync_q,
                               hblnk: hblnk_q, vblnk: vblnk_q};

endmodule

// File: tb/tb_vga_timing.sv
module tb_vga_timing;

    typedef struct {
        int ht, hbs, hss, hst;
        int vt, vbs, vss, vst;
        int fw;
    } geo_t;

    typedef struct packed {
        logic [10:0] h;
        logic [10:0] v;
        logic        hs, vs, hb, vb, ls, fs;
        logic [15:0] fc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b0;

    always #5 clk = ~clk;

    vga_timing_if #(.FRAME_CNT_W(16)) if_full ();
    vga_timing_if #(.FRAME_CNT_W(2))  if_small ();

    vga_timing #(.FRAME_CNT_W(16)) dut_full (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .vga (if_full)
    );

    vga_timing #(
        .FRAME_CNT_W   (2),
        .H_TOTAL       (11'd40),
        .H_BLANK_START (11'd28),
        .H_SYNC_START  (11'd30),
        .H_SYNC_TIME   (11'd5),
        .V_TOTAL       (11'd12),
        .V_BLANK_START (11'd9),
        .V_SYNC_START  (11'd10),
        .V_SYNC_TIME   (11'd1)
    ) dut_small (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .vga (if_small)
    );

    geo_t g_full  = '{ht: 1344, hbs: 1024, hss: 1048, hst: 136,
                      vt: 806,  vbs: 768,  vss: 771,  vst: 6, fw: 16};
    geo_t g_small = '{ht: 40, hbs: 28, hss: 30, hst: 5,
                      vt: 12, vbs: 9,  vss: 10, vst: 1, fw: 2};

    exp_t q_full[$];
    exp_t q_small[$];
    longint n_full  = 0;
    longint n_small = 0;

    int n_assert = 0;
    int n_fail   = 0;

    bit collect  = 1'b0;
    int ls_cnt   = 0;
    int fs_cnt   = 0;
    int fc_seen[$];

    // Reference: position is the number of enabled cycles since reset, laid out
    // row-major over the raster; frames completed is that index over the frame size.
    function automatic exp_t model(geo_t g, longint n, bit pulse);
        exp_t   e;
        longint line_idx;
        int     h, v;
        line_idx = n / g.ht;
        h    = int'(n % g.ht);
        v    = int'(line_idx % g.vt);
        e.h  = 11'(h);
        e.v  = 11'(v);
        e.hs = (h >= g.hss) && (h < g.hss + g.hst);
        e.vs = (v >= g.vss) && (v < g.vss + g.vst);
        e.hb = (h >= g.hbs);
        e.vb = (v >= g.vbs);
        e.ls = pulse && (n > 0) && (h == 0);
        e.fs = e.ls && (v == 0);
        e.fc = 16'((n / (longint'(g.ht) * g.vt)) % (longint'(1) << g.fw));
        return e;
    endfunction

    task automatic step(input bit r, input bit e);
        @(negedge clk);
        rst = r;
        en  = e;
        if (r) begin
            n_full  = 0;
            n_small = 0;
            q_full.push_back('0);
            q_small.push_back('0);
        end else if (e) begin
            n_full++;
            n_small++;
            q_full.push_back(model(g_full, n_full, 1'b1));
            q_small.push_back(model(g_small, n_small, 1'b1));
        end else begin
            q_full.push_back(model(g_full, n_full, 1'b0));
            q_small.push_back(model(g_small, n_small, 1'b0));
        end
    endtask

    task automatic check(input string nm, input exp_t a, input exp_t e);
        n_assert++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s t=%0t got h=%0d v=%0d hs=%b vs=%b hb=%b vb=%b ls=%b fs=%b fc=%0d want h=%0d v=%0d hs=%b vs=%b hb=%b vb=%b ls=%b fs=%b fc=%0d",
                     nm, $time, a.h, a.v, a.hs, a.vs, a.hb, a.vb, a.ls, a.fs, a.fc,
                     e.h, e.v, e.hs, e.vs, e.hb, e.vb, e.ls, e.fs, e.fc);
        end
    endtask

    task automatic check_int(input string nm, input int a, input int e);
        n_assert++;
        if (a != e) begin
            n_fail++;
            $display("FAIL %s got %0d want %0d", nm, a, e);
        end
    endtask

    // Monitor: the DUT presents a new output every edge; compare it with the
    // oldest expectation pushed by the driver.
    initial begin
        exp_t a;
        forever begin
            @(posedge clk);
            #1;
            if (q_full.size() > 0) begin
                a.h  = if_full.hcount;
                a.v  = if_full.vcount;
                a.hs = if_full.hsync;
                a.vs = if_full.vsync;
                a.hb = if_full.hblnk;
                a.vb = if_full.vblnk;
                a.ls = if_full.line_start;
                a.fs = if_full.frame_start;
                a.fc = if_full.frame_cnt;
                check("full", a, q_full.pop_front());
            end
            if (q_small.size() > 0) begin
                a.h  = if_small.tim.hcount;
                a.v  = if_small.tim.vcount;
                a.hs = if_small.tim.hsync;
                a.vs = if_small.tim.vsync;
                a.hb = if_small.tim.hblnk;
                a.vb = if_small.tim.vblnk;
                a.ls = if_small.line_start;
                a.fs = if_small.frame_start;
                a.fc = {14'b0, if_small.frame_cnt};
                check("small", a, q_small.pop_front());
                // raw ports must agree with the packed bundle
                check_int("small_raw_hcount", int'(if_small.hcount), int'(a.h));
            end
            if (collect) begin
                if (if_small.line_start) ls_cnt++;
                if (if_small.frame_start) begin
                    fs_cnt++;
                    fc_seen.push_back(int'(if_small.frame_cnt));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_fc[5];
        exp_fc = '{1, 2, 3, 0, 1};

        // reset, then 10 enabled cycles
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        repeat (10) step(1'b0, 1'b1);

        // mid-line reset on the full raster at hcount=700
        repeat (690) step(1'b0, 1'b1);
        repeat (3) step(1'b1, 1'b1);

        // two full lines at the real geometry: blank and sync windows, line wrap
        repeat (2 * 1344 + 5) step(1'b0, 1'b1);

        // stall on the last pixel of a small frame, then resume into the wrap
        while ((n_small % (40 * 12)) != (40 * 12 - 1)) step(1'b0, 1'b1);
        repeat (5) step(1'b0, 1'b0);
        step(1'b0, 1'b1);

        // randomized enable with one reset in the middle
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) step(1'b1, 1'($urandom_range(0, 1)));
            else           step(1'b0, $urandom_range(0, 9) < 8);
        end

        // five clean small frames from reset: pulse counts and frame_cnt wrap
        step(1'b1, 1'b1);
        collect = 1'b1;
        repeat (5 * 40 * 12) step(1'b0, 1'b1);
        repeat (3) step(1'b0, 1'b0);
        @(posedge clk);
        #2;
        collect = 1'b0;

        check_int("line_start_count", ls_cnt, 5 * 12);
        check_int("frame_start_count", fs_cnt, 5);
        check_int("frame_cnt_seq_len", fc_seen.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < fc_seen.size()) check_int("frame_cnt_seq", fc_seen[i], exp_fc[i]);
            else                    check_int("frame_cnt_seq_missing", -1, exp_fc[i]);
        end
        check_int("queue_drained", q_full.size() + q_small.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_timing.md
Name: vga_timing

Overview:
- Free-running 1024x768@60 raster timing generator, clocked at the 65 MHz pixel clock.
- Takes every timing constant from vga_pkg.
- Produces pixel/line counters, sync and blanking strobes, and frame/line markers.
- Sits directly downstream of the timing package and upstream of all draw stages (background, ball, paddles), which consume its outputs as one registered bundle.

Parameters:
- FRAME_CNT_W, 16, width of the completed-frame counter output.

Ports:
- clk  in  1  65 MHz pixel clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  pixel-advance enable; tie high for normal operation.
- hcount  out  11  horizontal position, 0..HOR_TOTAL_TIME-1 (0..1343).
- vcount  out  11  vertical position, 0..VER_TOTAL_TIME-1 (0..805).
- hsync  out  1  high while hcount is in 1048..1183.
- vsync  out  1  high while vcount is in 771..776.
- hblnk  out  1  high while hcount >= 1024.
- vblnk  out  1  high while vcount >= 768.
- line_start  out  1  one-cycle pulse on the cycle hcount wraps to 0.
- frame_start  out  1  one-cycle pulse on the cycle hcount and vcount both wrap to 0.
- frame_cnt  out  FRAME_CNT_W  number of frame_start pulses since reset, modulo 2^FRAME_CNT_W.

Behaviour:
- Interface: one clock; reset is synchronous and active-high; clock is clk, reset is rst.
- Reset: every output is 0 on the cycle after rst is sampled high. This includes hcount, vcount, all strobes, both pulses and frame_cnt. Reset mid-frame restarts the raster at (0,0) on the next edge with no partial-pulse glitch.
- First frame: it is NOT flagged by frame_start. The first frame_start pulse occurs at the first wrap, 1344*806 = 1,083,264 enabled cycles after reset release.
- Counting, each edge with en=1 and rst=0:
  - hcount == 1343: hcount <= 0.
  - Otherwise: hcount <= hcount+1.
  - At the hcount wrap, vcount <= (vcount == 805) ? 0 : vcount+1.
  - Counters never exceed the maximums above. The registered value is always in range.
- Alignment: hsync, vsync, hblnk and vblnk are registered. Each is decoded from the next-state counter values, so every strobe describes the same pixel as the hcount/vcount presented on the same cycle. Latency from counter to strobe is zero cycles as seen at the outputs.
- Window boundaries, all derived from package constants:
  - hsync = HOR_SYNC_START <= h < HOR_SYNC_START+HOR_SYNC_TIME.
  - vsync = VER_SYNC_START <= v < VER_SYNC_START+VER_SYNC_TIME.
  - hblnk = h >= HOR_BLANK_START.
  - vblnk = v >= VER_BLANK_START.
- Sync polarity: sync strobes are active-high at this boundary. Inversion to VESA negative polarity is done only at the top-level pin assignment.
- Pulses:
  - line_start = 1 on the cycle where the output hcount is 0 as a result of a wrap; 0 otherwise.
  - frame_start = 1 where the output hcount and vcount are both 0 from a wrap. frame_start implies line_start.
- frame_cnt: increments on the same edge that raises frame_start, and wraps silently at 2^FRAME_CNT_W.
- Enable: when en=0, counters, strobes and frame_cnt hold their values. line_start and frame_start are forced to 0, so there is no repeated pulse while stalled. The next en=1 edge resumes exactly where it stopped.
- Simultaneous events: rst has priority over en. A wrap coinciding with en deassertion does not happen; the wrap occurs on the next enabled edge.

Decomposition:
- Add to vga_pkg:
  - HCNT_W = 11 and VCNT_W = 11.
  - A packed struct vga_tim_t holding {hcount, vcount, hsync, vsync, hblnk, vblnk}, for downstream stages to pass along.
- The module has no sub-module. It is two cascaded counters plus a compare/decode block.
- The sync/blank decode is written as a package function, in_window(value, start, len). Draw stages can reuse it for rectangle hit tests.

Test Plan:
- Reset, then 10 cycles with en=1 -> hcount=10, vcount=0, all strobes 0, frame_cnt=0; hold rst 3 cycles mid-line at hcount=700 -> hcount=0 on the edge after rst, no line_start.
- Run one line -> hblnk rises exactly when hcount=1024; hsync high for hcount 1048..1183 (136 cycles); line_start high when hcount returns to 0 with vcount=1.
- Run one full frame -> vblnk rises at vcount=768; vsync high for vcount 771..776 (6 lines, 8064 cycles); frame_start after exactly 1,083,264 enabled cycles, frame_cnt=1.
- Toggle en low for 5 cycles at hcount=1343, vcount=805 -> all outputs frozen, no pulses; first enabled edge gives hcount=0, vcount=0, frame_start=1, line_start=1.
- Run 3 frames, checker samples every cycle -> hcount never >1343, vcount never >805; exactly 3 frame_start and 2418 line_start pulses after the first wrap window; strobes consistent with the in_window reference model.
- FRAME_CNT_W=2, run 5 frames -> frame_cnt sequence 1,2,3,0,1.
